fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch from the 24-bit instruction memory (IMEM_DEPTH words).
- Presents one instruction at a time to decode over a valid/ready handshake.
- Absorbs decode back-pressure, branch redirects from execute, and end-of-program halt.
- Sits between the instruction memory and the decode stage; replaces free-running PC increment with a controlled request/response sequence.

---
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter and walks instruction memory one word at a time:
//   issue a single read, wait for its data, hand the word to decode over a
//   valid/ready handshake, then move on. Branch redirects from execute can
//   arrive in any state and retarget the PC. A read already in flight when a
//   redirect lands is allowed to return and is then thrown away. Running off
//   the end of the program parks the block in HALT until a redirect arrives.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   imem_req / imem_addr    one-cycle read strobe and address to instruction memory
//   imem_rvalid/imem_rdata  read return, one cycle, >= 1 cycle after the strobe
//   if_valid/if_instr/if_pc instruction offered to decode
//   dec_ready               decode accepts the offered instruction this cycle
//   redirect_valid/_pc      taken branch/jump and its target
//   halted                  high while parked at end of program
//   fetch_count             instructions accepted by decode since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int INSTR_W    = 24,
  parameter int IMEM_DEPTH = 100,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               dec_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  // First address past the end of the program. IMEM_DEPTH < 2**ADDR_W, so
  // pc+1 always reaches this bound before it could wrap.
  localparam logic [ADDR_W-1:0] PC_END = ADDR_W'(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 drop_q, drop_d;        // in-flight read belongs to a stale path
  logic                 if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic pc_at_end;
  logic tgt_at_end;
  logic handshake;

  assign pc_at_end  = (pc_q >= PC_END);
  assign tgt_at_end = (redirect_pc >= PC_END);
  assign handshake  = if_valid_q && dec_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    cnt_d      = cnt_q;

    if (redirect_valid) begin
      // Redirect beats everything but reset: the offered instruction is
      // flushed without a handshake, even if decode is ready this cycle.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      unique case (state_q)
        // Read was just issued and will still come back: mark it stale.
        S_REQ: begin
          drop_d  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // The outstanding read retires now, so nothing is left to drop.
            drop_d  = 1'b0;
            state_d = tgt_at_end ? S_HALT : S_REQ;
          end else begin
            // Still waiting; the halt check is deferred to the discard path.
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: begin
          drop_d  = 1'b0;
          state_d = tgt_at_end ? S_HALT : S_REQ;
        end
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = pc_at_end ? S_HALT : S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = pc_at_end ? S_HALT : S_REQ;
            end else begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + ADDR_W'(1);
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // pc_q already points past the held word, so the end check here
          // decides whether another fetch is worth issuing.
          if (handshake) begin
            if_valid_d = 1'b0;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = pc_at_end ? S_HALT : S_REQ;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = (state_q == S_REQ);
    imem_addr   = (state_q == S_REQ) ? pc_q : '0;
    halted      = (state_q == S_HALT);
    if_valid    = if_valid_q;
    if_instr    = if_instr_q;
    if_pc       = if_pc_q;
    fetch_count = cnt_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed scenarios with hand-computed expectations, followed by a long
//   randomized run. An instruction-memory responder with variable latency
//   drives the read return; a transaction-level model of the fetch rules
//   predicts every output each cycle and a single compare process checks it.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int ADDR_W  = 7;
  localparam int INSTR_W = 24;
  localparam int DEPTH   = 100;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               dec_ready = 1'b1;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  logic [INSTR_W-1:0] mem [0:127];
  int                 mem_k = 1;
  bit                 mp_pend = 1'b0;
  int                 mp_due = 0;
  logic [ADDR_W-1:0]  mp_addr = '0;

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = (i < 5) ? INSTR_W'(i + 1) : INSTR_W'($urandom);
  end

  // Return data k cycles after the strobe; a newer strobe replaces a pending one.
  initial forever begin
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = INSTR_W'($urandom);
    if (mp_pend && cyc == mp_due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[mp_addr];
      mp_pend     = 1'b0;
    end
    if (imem_req === 1'b1) begin
      mp_pend = 1'b1;
      mp_due  = cyc + mem_k;
      mp_addr = imem_addr;
    end
  end

  // ---------------- reference model ----------------
  // Inputs as seen by the design at each rising edge.
  logic              p_rst = 1'b1;
  logic              p_redir = 1'b0;
  logic [ADDR_W-1:0] p_rpc = '0;
  logic              p_rvalid = 1'b0;
  logic              p_ready = 1'b0;
  always @(posedge clk) begin
    p_rst    <= reset;
    p_redir  <= redirect_valid;
    p_rpc    <= redirect_pc;
    p_rvalid <= imem_rvalid;
    p_ready  <= dec_ready;
  end

  bit                 m_boot, m_issue, m_fly, m_disc, m_have, m_halt;
  logic [ADDR_W-1:0]  m_pc, m_ipc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_cnt;

  task automatic next_fetch();
    if (int'(m_pc) >= DEPTH) m_halt = 1'b1;
    else m_issue = 1'b1;
  endtask

  task automatic model_step();
    bit busy;
    if (p_rst) begin
      m_boot = 1'b1; m_issue = 1'b0; m_fly = 1'b0; m_disc = 1'b0;
      m_have = 1'b0; m_halt = 1'b0; m_pc = '0; m_ipc = '0; m_instr = '0; m_cnt = 0;
    end else if (p_redir) begin
      // A read is still out there if it was just sent or has not come back.
      busy    = m_issue || (m_fly && !p_rvalid);
      m_pc    = p_rpc;
      m_have  = 1'b0;
      m_boot  = 1'b0;
      m_issue = 1'b0;
      m_halt  = 1'b0;
      m_fly   = busy;
      m_disc  = busy;
      if (!busy) begin
        if (int'(p_rpc) >= DEPTH) m_halt = 1'b1;
        else m_issue = 1'b1;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
      next_fetch();
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_fly   = 1'b1;
    end else if (m_fly && p_rvalid) begin
      m_fly = 1'b0;
      if (m_disc) begin
        m_disc = 1'b0;
        next_fetch();
      end else begin
        m_have  = 1'b1;
        m_ipc   = m_pc;
        m_instr = mem[m_pc];
        m_pc    = m_pc + 1'b1;
      end
    end else if (m_have && p_ready) begin
      m_have = 1'b0;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      next_fetch();
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
    chk("imem_req", 32'(imem_req), 32'(m_issue));
    if (m_issue) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(m_have));
    if (m_have) begin
      chk("if_pc", 32'(if_pc), 32'(m_ipc));
      chk("if_instr", 32'(if_instr), 32'(m_instr));
    end
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  end

  // ---------------- directed + random stimulus ----------------
  function automatic bit cond(input int sel);
    case (sel)
      0:       return imem_req === 1'b1;
      1:       return if_valid === 1'b1;
      default: return halted === 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int lim, input string nm);
    int n;
    n = 0;
    while (!cond(sel) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(cond(sel)), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);

    // Bring-up, k=1, decode always ready: cycle 0 is IDLE.
    reset = 1'b0;
    chk("t1_c0_req",    32'(imem_req), 0);
    chk("t1_c0_valid",  32'(if_valid), 0);
    chk("t1_c0_halted", 32'(halted), 0);
    chk("t1_c0_count",  32'(fetch_count), 0);
    chk("t1_c0_ifpc",   32'(if_pc), 0);
    chk("t1_c0_instr",  32'(if_instr), 0);
    @(negedge clk);
    chk("t1_c1_req",  32'(imem_req), 1);
    chk("t1_c1_addr", 32'(imem_addr), 0);
    @(negedge clk);
    chk("t1_c2_valid", 32'(if_valid), 0);
    @(negedge clk);
    chk("t1_c3_valid", 32'(if_valid), 1);
    chk("t1_c3_instr", 32'(if_instr), 32'h000001);
    chk("t1_c3_pc",    32'(if_pc), 0);
    for (int i = 1; i < 5; i++) begin
      repeat (3) @(negedge clk);
      chk("t1_valid", 32'(if_valid), 1);
      chk("t1_pc",    32'(if_pc), 32'(i));
      chk("t1_instr", 32'(if_instr), 32'(i + 1));
    end
    @(negedge clk);
    chk("t1_count5", 32'(fetch_count), 5);
    chk("t1_req5",   32'(imem_req), 1);
    chk("t1_addr5",  32'(imem_addr), 5);

    // Back-pressure for six cycles on the word at pc 5.
    dec_ready = 1'b0;
    wait_until(1, 10, "bp_wait_valid");
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(if_valid), 1);
      chk("bp_pc",    32'(if_pc), 5);
      chk("bp_instr", 32'(if_instr), 32'(mem[5]));
      chk("bp_noreq", 32'(imem_req), 0);
      chk("bp_count", 32'(fetch_count), 5);
      if (i < 5) @(negedge clk);
    end
    dec_ready = 1'b1;
    mem_k     = 3;
    @(negedge clk);
    chk("bp_after_valid", 32'(if_valid), 0);
    chk("bp_after_count", 32'(fetch_count), 6);
    chk("bp_after_req",   32'(imem_req), 1);
    chk("bp_after_addr",  32'(imem_addr), 6);

    // Redirect while waiting on a k=3 read.
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 7'd7;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_until(0, 10, "rw_wait_req");
    chk("rw_addr", 32'(imem_addr), 7);
    wait_until(1, 10, "rw_wait_valid");
    chk("rw_pc",    32'(if_pc), 7);
    chk("rw_instr", 32'(if_instr), 32'(mem[7]));
    chk("rw_count", 32'(fetch_count), 6);
    mem_k = 1;

    // Redirect in the same cycle decode would accept.
    @(negedge clk);
    chk("rh_count7", 32'(fetch_count), 7);
    wait_until(1, 10, "rh_wait_valid");
    chk("rh_pc8", 32'(if_pc), 8);
    redirect_valid = 1'b1; redirect_pc = 7'd20; dec_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rh_flush_valid", 32'(if_valid), 0);
    chk("rh_flush_count", 32'(fetch_count), 7);
    chk("rh_req",         32'(imem_req), 1);
    chk("rh_addr",        32'(imem_addr), 20);
    wait_until(1, 10, "rh_wait_valid20");
    chk("rh_pc20",    32'(if_pc), 20);
    chk("rh_instr20", 32'(if_instr), 32'(mem[20]));

    // End of program: last words 97..99, then park.
    redirect_valid = 1'b1; redirect_pc = 7'd97;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("eop_count", 32'(fetch_count), 7);
    chk("eop_req",   32'(imem_req), 1);
    chk("eop_addr",  32'(imem_addr), 97);
    for (int i = 0; i < 3; i++) begin
      wait_until(1, 10, "eop_wait_valid");
      chk("eop_pc", 32'(if_pc), 32'(97 + i));
      @(negedge clk);
    end
    chk("eop_halted", 32'(halted), 1);
    chk("eop_count10", 32'(fetch_count), 10);
    mem_k = 3;
    for (int i = 0; i < 10; i++) begin
      chk("halt_stay", 32'(halted), 1);
      chk("halt_noreq", 32'(imem_req), 0);
      chk("halt_novalid", 32'(if_valid), 0);
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 7'd1;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("unhalt_halted", 32'(halted), 0);
    chk("unhalt_req",    32'(imem_req), 1);
    chk("unhalt_addr",   32'(imem_addr), 1);

    // Reset while a k=3 read is in flight.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_k = 1;
    chk("rst_req",    32'(imem_req), 0);
    chk("rst_valid",  32'(if_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count",  32'(fetch_count), 0);
    chk("rst_ifpc",   32'(if_pc), 0);
    chk("rst_instr",  32'(if_instr), 0);
    @(negedge clk);
    chk("rst_req0",  32'(imem_req), 1);
    chk("rst_addr0", 32'(imem_addr), 0);
    @(negedge clk);
    chk("rst_stale_ignored", 32'(if_valid), 0);
    @(negedge clk);
    chk("rst_valid0", 32'(if_valid), 1);
    chk("rst_pc0",    32'(if_pc), 0);
    chk("rst_instr0", 32'(if_instr), 32'h000001);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dec_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc    = (($urandom % 8) == 0) ? ADDR_W'($urandom_range(100, 127))
                                             : ADDR_W'($urandom_range(0, 99));
      reset          = ($urandom % 300) == 0;
      mem_k          = $urandom_range(1, 4);
    end
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
